// File: rtl/simon_sequence_player_if.sv
// Bus between the Simon sequence player and its controller/checker:
// game control pulses, divider tick input, LED outputs and sequence read port.
interface simon_sequence_player_if #(
  parameter int MAX_LEN = 16
);
  localparam int IW = $clog2(MAX_LEN);

  logic          tick_toggle;
  logic          start;
  logic          clear;
  logic [IW-1:0] rd_idx;
  logic [1:0]    rd_color;
  logic [3:0]    led;
  logic          busy;
  logic          done;
  logic [IW:0]   seq_len;
  logic          full;

  modport master (
    output tick_toggle, start, clear, rd_idx,
    input  rd_color, led, busy, done, seq_len, full
  );

  modport slave (
    input  tick_toggle, start, clear, rd_idx,
    output rd_color, led, busy, done, seq_len, full
  );
endinterface

// File: rtl/simon_sequence_player.sv
// Simon Says sequence store and player: appends one LFSR colour per round and
// replays the whole sequence on the LEDs, one step per divider edge.
module simon_sequence_player #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic                    clk,
  input logic                    reset,
  simon_sequence_player_if.slave bus
);
  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    APPEND,
    WAIT_SYNC,
    SHOW,
    GAP,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW:0]   len_q, len_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          tick_q, tick_d;
  logic [3:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    mem_q [MAX_LEN];
  logic          mem_we;
  logic          tick;
  logic          full;
  logic          last_step;
  logic [IW-1:0] idx_next;

  assign tick      = bus.tick_toggle ^ tick_q;
  assign full      = (len_q == (IW+1)'(MAX_LEN));
  assign last_step = ((IW+1)'(idx_q) == len_q - (IW+1)'(1));
  assign idx_next  = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    led_d   = led_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    tick_d  = bus.tick_toggle;
    // x^8+x^6+x^5+x^4+1, free-running so colours depend on player timing
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (bus.clear) begin
      state_d = IDLE;
      idx_d   = '0;
      len_d   = '0;
      led_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          led_d = '0;
          if (bus.start) begin
            idx_d   = '0;
            state_d = full ? WAIT_SYNC : APPEND;
          end
        end
        APPEND: begin
          mem_we  = 1'b1;
          len_d   = len_q + (IW+1)'(1);
          idx_d   = '0;
          state_d = WAIT_SYNC;
        end
        WAIT_SYNC: begin
          if (tick) begin
            led_d   = 4'b0001 << mem_q[idx_q];
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (tick) begin
            led_d   = '0;
            state_d = GAP;
          end
        end
        GAP: begin
          if (tick) begin
            if (last_step) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              idx_d   = idx_next;
              led_d   = 4'b0001 << mem_q[idx_next];
              state_d = SHOW;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      tick_q  <= 1'b0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      lfsr_q  <= lfsr_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (mem_we) mem_q[len_q[IW-1:0]] <= lfsr_q[1:0];
    end
  end

  assign bus.rd_color = mem_q[bus.rd_idx];
  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.seq_len  = len_q;
  assign bus.full     = full;
endmodule

// File: tb/tb_simon_sequence_player.sv
// Self-checking bench for simon_sequence_player: directed rounds with random
// idle gaps, checked against a queue-based model of the stored sequence.
module tb_simon_sequence_player;
  localparam int ML = 4;
  localparam int IW = $clog2(ML);
  localparam int TP = 8;

  logic clk = 1'b0;
  logic reset;

  simon_sequence_player_if #(.MAX_LEN(ML)) bus ();

  simon_sequence_player #(.MAX_LEN(ML), .LFSR_SEED(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] m_lfsr;
  logic [1:0] seq [$];

  // Reference LFSR: new bit is the parity of the tapped bits (mask B8).
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem();
    for (int i = 0; i < seq.size(); i++) begin
      bus.rd_idx = IW'(i);
      #1;
      chk($sformatf("rd_color[%0d]", i), 32'(bus.rd_color), 32'(seq[i]));
    end
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 9);
    repeat (n) @(negedge clk);
  endtask

  // One round: start, optional append, then 2L+1 divider edges of playback.
  task automatic play(input int clear_t, input bit busy_start);
    int   L;
    int   t;
    int   c;
    bit   app;
    bit   toggled;
    logic [3:0] exp_led;
    app = (seq.size() < ML);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (app) seq.push_back(m_lfsr[1:0]);
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("len_before_append", 32'(bus.seq_len), app ? seq.size() - 1 : seq.size());
    @(negedge clk);
    L = seq.size();
    chk("len_after_append", 32'(bus.seq_len), L);
    t = 0;
    c = 0;
    while (t < 2 * L + 1 && c < 2000) begin
      toggled = (c % TP == 0);
      if (toggled) bus.tick_toggle = ~bus.tick_toggle;
      if (busy_start && t == 2 && c % TP == 3) bus.start = 1'b1;
      if (clear_t != 0 && t == clear_t && c % TP == 3) begin
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        seq.delete();
        chk("clr_led", 32'(bus.led), 0);
        chk("clr_busy", 32'(bus.busy), 0);
        chk("clr_len", 32'(bus.seq_len), 0);
        chk("clr_done", 32'(bus.done), 0);
        @(negedge clk);
        chk("clr_done_next", 32'(bus.done), 0);
        chk("clr_busy_next", 32'(bus.busy), 0);
        return;
      end
      @(negedge clk);
      bus.start = 1'b0;
      if (toggled) t++;
      c++;
      exp_led = (t % 2 == 1 && t < 2 * L + 1) ? (4'b0001 << seq[(t - 1) / 2]) : 4'b0000;
      chk($sformatf("led t=%0d", t), 32'(bus.led), 32'(exp_led));
      chk("busy_play", 32'(bus.busy), 1);
      chk("done_play", 32'(bus.done), (t == 2 * L + 1) ? 1 : 0);
      chk("len_play", 32'(bus.seq_len), L);
    end
    if (t < 2 * L + 1) chk("playback_timeout", 0, 1);
    @(negedge clk);
    chk("done_drop", 32'(bus.done), 0);
    chk("busy_drop", 32'(bus.busy), 0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.tick_toggle = 1'b1;
    bus.start       = 1'b0;
    bus.clear       = 1'b0;
    bus.rd_idx      = '0;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(bus.led), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_len", 32'(bus.seq_len), 0);
    chk("rst_full", 32'(bus.full), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("spurious_tick_busy", 32'(bus.busy), 0);
    chk("spurious_tick_led", 32'(bus.led), 0);

    // Four rounds fill the MAX_LEN=4 sequence
    for (int r = 0; r < 4; r++) begin
      idle_gap();
      play(0, 1'b0);
      chk_mem();
      chk("full_round", 32'(bus.full), (r == 3) ? 1 : 0);
    end

    // Saturated: replay only, with an ignored start while busy
    idle_gap();
    play(0, 1'b1);
    chk_mem();
    chk("full_sat", 32'(bus.full), 1);
    chk("len_sat", 32'(bus.seq_len), ML);

    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    seq.delete();
    chk("clear_len", 32'(bus.seq_len), 0);
    chk("clear_full", 32'(bus.full), 0);

    // Start and clear together in IDLE: clear wins
    play(0, 1'b0);
    idle_gap();
    play(0, 1'b0);
    chk("len_two", 32'(bus.seq_len), 2);
    bus.start = 1'b1;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clear = 1'b0;
    seq.delete();
    chk("sc_len", 32'(bus.seq_len), 0);
    chk("sc_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("sc_busy_next", 32'(bus.busy), 0);
    chk("sc_len_next", 32'(bus.seq_len), 0);

    // Clear during the second SHOW of round 3, then a fresh length-1 round
    play(0, 1'b0);
    idle_gap();
    play(0, 1'b0);
    idle_gap();
    play(3, 1'b0);
    idle_gap();
    play(0, 1'b0);
    chk("len_after_clear", 32'(bus.seq_len), 1);
    chk_mem();

    // Reset mid-playback
    idle_gap();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.tick_toggle = ~bus.tick_toggle;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seq.delete();
    chk("mid_rst_led", 32'(bus.led), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_len", 32'(bus.seq_len), 0);
    idle_gap();
    play(0, 1'b0);
    chk_mem();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
